// File: rtl/mem_arbiter.sv
// Purpose: shares one physical memory port between the IFU (read-only) and the LSU (read/write).
// Latency: the response strobe comes LATENCY+2 cycles after the request handshake; accesses are serialised.
// Backpressure: ready is offered only in IDLE (round-robin on ties); responses cannot be stalled.
module mem_arbiter #(
    parameter int unsigned LATENCY    = 2,
    parameter logic [63:0] RESET_ADDR = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [63:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [63:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [63:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [63:0] lsu_rdata,
    output logic [63:0] mem_raddr,
    output logic [63:0] mem_waddr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    output logic        mem_write_en,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_lsu_q;   // 1 when the most recent grant went to the LSU
    logic        owner_lsu_q;  // owner of the access currently in flight
    logic [63:0] addr_q;
    logic        wen_q;
    logic [63:0] wdata_q;
    logic [7:0]  wmask_q;
    logic [63:0] ifu_rdata_q;
    logic [63:0] lsu_rdata_q;
    logic        grant_ifu;
    logic        grant_lsu;
    logic        capture;      // last cycle before RESP: sample mem_rdata

    // Arbitration, next-state and capture strobe; grants are only offered in IDLE outside reset.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        capture   = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (rst_n) begin
                    if (ifu_req_valid && lsu_req_valid) begin
                        grant_lsu = !last_lsu_q;
                        grant_ifu = last_lsu_q;
                    end else begin
                        grant_ifu = ifu_req_valid;
                        grant_lsu = lsu_req_valid;
                    end
                end
                if (grant_ifu || grant_lsu) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (LATENCY == 0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = 4'(LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, wait counter and round-robin history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            last_lsu_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant_ifu) begin
                last_lsu_q <= 1'b0;
            end else if (grant_lsu) begin
                last_lsu_q <= 1'b1;
            end
        end
    end

    // Request latch: fields are taken in the handshake cycle and held until the next grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_lsu_q <= 1'b0;
            addr_q      <= RESET_ADDR;
            wen_q       <= 1'b0;
            wdata_q     <= 64'd0;
            wmask_q     <= 8'd0;
        end else if (grant_ifu) begin
            owner_lsu_q <= 1'b0;
            addr_q      <= ifu_addr;
            wen_q       <= 1'b0;
            wdata_q     <= 64'd0;
            wmask_q     <= 8'd0;
        end else if (grant_lsu) begin
            owner_lsu_q <= 1'b1;
            addr_q      <= lsu_addr;
            wen_q       <= lsu_wen;
            wdata_q     <= lsu_wdata;
            wmask_q     <= lsu_wmask;
        end
    end

    // Per-port read data: loaded on entry to RESP and held until that port's next response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifu_rdata_q <= 64'd0;
            lsu_rdata_q <= 64'd0;
        end else if (capture) begin
            if (owner_lsu_q) begin
                lsu_rdata_q <= wen_q ? 64'd0 : mem_rdata;
            end else begin
                ifu_rdata_q <= mem_rdata;
            end
        end
    end

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;
    assign ifu_resp_valid = (state_q == RESP) && !owner_lsu_q;
    assign lsu_resp_valid = (state_q == RESP) && owner_lsu_q;
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_rdata      = lsu_rdata_q;

    // Address and write fields come straight from the latch so they hold between accesses;
    // the write strobe exists only in the single ISSUE cycle of a store.
    assign mem_raddr    = addr_q;
    assign mem_waddr    = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_wmask    = wmask_q;
    assign mem_write_en = (state_q == ISSUE) && wen_q;

endmodule
